// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
interface fp_mult_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        exception;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, exception
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, result, overflow, underflow, exception
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined IEEE-754 single multiplier with valid/ready backpressure.
// Define FMUL_RNE_EN for round-to-nearest-even; otherwise the product is truncated.
module fp_mult_pipe #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input logic          clk,
  input logic          rst_n,
  fp_mult_pipe_if.slave bus
);

  typedef enum logic [1:0] {SP_NORM, SP_NAN, SP_INF, SP_ZERO} special_t;

  logic              v1, v2, v3;
  logic              adv1, adv2, adv3;
  logic              sign1, sign2;
  logic signed [9:0] e1, e2;
  logic [22:0]       ma1, mb1;
  special_t          sp1, sp2;
  logic [47:0]       p2;
  logic [31:0]       res_q;
  logic              ovf_q, unf_q, exc_q;

  // Bubble collapse: a stage may load whenever its contents move on this cycle.
  assign adv3 = !v3 || bus.out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.result    = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.exception = exc_q;

  logic [7:0]        ea, eb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  special_t          sp_in;
  logic signed [9:0] e_in;

  always_comb begin
    ea     = bus.A[30:23];
    eb     = bus.B[30:23];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (bus.A[22:0] == '0);
    b_inf  = (eb == 8'hFF) && (bus.B[22:0] == '0);
    a_nan  = (ea == 8'hFF) && (bus.A[22:0] != '0);
    b_nan  = (eb == 8'hFF) && (bus.B[22:0] != '0);
    e_in   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      sp_in = SP_NAN;
    else if (a_inf || b_inf)
      sp_in = SP_INF;
    else if (a_zero || b_zero)
      sp_in = SP_ZERO;
    else
      sp_in = SP_NORM;
  end

  logic [22:0]       mant;
  logic              guard, sticky, round_up, carry;
  logic [22:0]       mant_r;
  logic signed [9:0] e_n, e_r;
  logic [31:0]       res_n;
  logic              ovf_n, unf_n, exc_n;

  always_comb begin
    mant   = p2[47] ? p2[46:24] : p2[45:23];
    guard  = p2[47] ? p2[23] : p2[22];
    sticky = p2[47] ? (|p2[22:0]) : (|p2[21:0]);
    e_n    = e2 + (p2[47] ? 10'sd1 : 10'sd0);
`ifdef FMUL_RNE_EN
    round_up = guard && (sticky || mant[0]);
`else
    round_up = 1'b0;
`endif
    {carry, mant_r} = {1'b0, mant} + {23'd0, round_up};
    e_r   = carry ? (e_n + 10'sd1) : e_n;
    res_n = {sign2, e_r[7:0], mant_r};
    ovf_n = 1'b0;
    unf_n = 1'b0;
    exc_n = 1'b0;
    unique case (sp2)
      SP_NAN:  begin res_n = QNAN; exc_n = 1'b1; end
      SP_INF:  res_n = {sign2, 8'hFF, 23'h0};
      SP_ZERO: res_n = {sign2, 31'h0};
      default: begin
        if (e_r >= 10'sd255) begin
          res_n = {sign2, 8'hFF, 23'h0};
          ovf_n = 1'b1;
        end else if (e_r <= 10'sd0) begin
          res_n = {sign2, 31'h0};
          unf_n = 1'b1;
        end
      end
    endcase
  end

`ifndef FMUL_RNE_EN
  logic unused_round_bits;
  assign unused_round_bits = guard ^ sticky;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      sign1 <= 1'b0;
      sign2 <= 1'b0;
      e1    <= '0;
      e2    <= '0;
      ma1   <= '0;
      mb1   <= '0;
      sp1   <= SP_ZERO;
      sp2   <= SP_ZERO;
      p2    <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          sign1 <= bus.A[31] ^ bus.B[31];
          e1    <= e_in;
          ma1   <= bus.A[22:0];
          mb1   <= bus.B[22:0];
          sp1   <= sp_in;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          sign2 <= sign1;
          e2    <= e1;
          sp2   <= sp1;
          p2    <= 48'({1'b1, ma1}) * 48'({1'b1, mb1});
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          res_q <= res_n;
          ovf_q <= ovf_n;
          unf_q <= unf_n;
          exc_q <= exc_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed-vector bench for fp_mult_pipe; honours FMUL_RNE_EN for the rounding vector.
module tb_fp_mult_pipe;
  logic clk;
  logic rst_n;
  int unsigned n_vec;
  int unsigned n_err;

  fp_mult_pipe_if bus ();

  fp_mult_pipe #(.QNAN(32'h7FC00000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef FMUL_RNE_EN
  localparam logic [31:0] EXP_RND = 32'h3FC00002;
`else
  localparam logic [31:0] EXP_RND = 32'h3FC00001;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.overflow, bus.underflow, bus.exception};
  endfunction

  // Single isolated operation with out_ready high: visible after the third edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [2:0] exp_f);
    bus.A = a;
    bus.B = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".v_c1"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, ".v_c2"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, ".v_c3"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".result"}, bus.result, exp_r);
    chk({tag, ".flags"}, flags(), {29'd0, exp_f});
    tick();
    chk({tag, ".v_done"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", bus.result, 32'h0);
    chk("rst.flags", flags(), 32'h0);
    rst_n = 1'b1;

    // flags order: {overflow, underflow, exception}
    run_op("basic", 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    run_op("round", 32'h3FC00000, 32'h3F800001, EXP_RND, 3'b000);
    run_op("ovf", 32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100);
    run_op("unf", 32'h00800000, 32'h3F000000, 32'h00000000, 3'b010);
    run_op("inf0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
    run_op("denorm", 32'h00400000, 32'h40000000, 32'h00000000, 3'b000);
    run_op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001);
    run_op("infx", 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);

    // Back-to-back streaming
    bus.out_ready = 1'b1;
    bus.A = 32'hC0CCCCCC; bus.B = 32'hBF000000; bus.in_valid = 1'b1;
    tick();
    bus.A = 32'h40CCCCCC; bus.B = 32'hBF000000;
    chk("strm.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("strm.v0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("strm.v1", 32'(bus.out_valid), 32'd1);
    chk("strm.r1", bus.result, 32'h404CCCCC);
    tick();
    chk("strm.v2", 32'(bus.out_valid), 32'd1);
    chk("strm.r2", bus.result, 32'hC04CCCCC);
    tick();
    chk("strm.vend", 32'(bus.out_valid), 32'd0);

    // Backpressure: fill three stages, fourth offer must stall
    bus.out_ready = 1'b0;
    bus.A = 32'h40000000; bus.B = 32'h40400000; bus.in_valid = 1'b1;
    chk("bp.rdy1", 32'(bus.in_ready), 32'd1);
    tick();
    bus.A = 32'h40000000; bus.B = 32'h40000000;
    chk("bp.rdy2", 32'(bus.in_ready), 32'd1);
    tick();
    bus.A = 32'h40400000; bus.B = 32'h40400000;
    chk("bp.rdy3", 32'(bus.in_ready), 32'd1);
    tick();
    bus.A = 32'h3F800000; bus.B = 32'h40A00000;
    chk("bp.rdy4", 32'(bus.in_ready), 32'd0);
    chk("bp.hold_v", 32'(bus.out_valid), 32'd1);
    chk("bp.hold_r", bus.result, 32'h40C00000);
    tick();
    tick();
    chk("bp.stall_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp.stall_r", bus.result, 32'h40C00000);
    bus.out_ready = 1'b1;
    #1;
    chk("bp.rdy_comb", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp.o2_v", 32'(bus.out_valid), 32'd1);
    chk("bp.o2", bus.result, 32'h40800000);
    tick();
    chk("bp.o3_v", 32'(bus.out_valid), 32'd1);
    chk("bp.o3", bus.result, 32'h41100000);
    tick();
    chk("bp.o4_v", 32'(bus.out_valid), 32'd1);
    chk("bp.o4", bus.result, 32'h40A00000);
    tick();
    chk("bp.drained", 32'(bus.out_valid), 32'd0);

    // Reset with two operations in flight
    bus.A = 32'h40000000; bus.B = 32'h40400000; bus.in_valid = 1'b1;
    tick();
    bus.A = 32'h40400000; bus.B = 32'h40400000;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.valid", 32'(bus.out_valid), 32'd0);
    chk("mrst.result", bus.result, 32'h0);
    chk("mrst.flags", flags(), 32'h0);
    tick();
    chk("mrst.gone1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mrst.gone2", 32'(bus.out_valid), 32'd0);
    run_op("post_rst", 32'h40400000, 32'h40400000, 32'h41100000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
